// File: rtl/encoder_scanner.sv
// encoder_scanner: scans 8 rotary-encoder A/B pairs through an external 8:1 mux and emits
// a channel-tagged one-cycle sample strobe plus sticky per-channel illegal-jump flags.
// Optional build macro ENCODER_SCANNER_FILTER_EN: double-sample each channel, drop on disagreement.
module encoder_scanner #(
  parameter int SETTLE_CYCLES = 16,
  parameter int NUM_CHANNELS  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       enc_a,
  input  logic       enc_b,
  output logic [2:0] mux_sel,
  output logic [2:0] chan,
  output logic       a_q,
  output logic       b_q,
  output logic       valid,
  output logic [7:0] err,
  input  logic [7:0] err_clr
);

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

`ifdef ENCODER_SCANNER_FILTER_EN
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, SAMPLE2} state_t;
`else
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;
`endif

  state_t state, state_nxt;

  logic [7:0]              settle_cnt;
  logic                    load_cnt;
  logic                    sample_fire;  // closing edge of the slot: mux advances
  logic                    sample_ok;    // sample accepted: strobe, error check, history update
  logic [NUM_CHANNELS-1:0] last_a;
  logic [NUM_CHANNELS-1:0] last_b;
  logic [NUM_CHANNELS-1:0] primed;
  logic [NUM_CHANNELS-1:0] err_set;

`ifdef ENCODER_SCANNER_FILTER_EN
  logic s1_a;
  logic s1_b;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; dropping enable anywhere in a slot abandons it without a strobe
  always_comb begin
    state_nxt   = state;
    sample_fire = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!enable)              state_nxt = IDLE;
        else if (settle_cnt == 0) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else begin
`ifdef ENCODER_SCANNER_FILTER_EN
          state_nxt = SAMPLE2;
`else
          state_nxt   = SETTLE;
          sample_fire = 1'b1;
`endif
        end
      end
`ifdef ENCODER_SCANNER_FILTER_EN
      SAMPLE2: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else begin
          state_nxt   = SETTLE;
          sample_fire = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Settle counter is reloaded on every entry into SETTLE (from IDLE or from a sample)
  assign load_cnt = (state_nxt == SETTLE) && (state != SETTLE);

`ifdef ENCODER_SCANNER_FILTER_EN
  assign sample_ok = sample_fire && (enc_a == s1_a) && (enc_b == s1_b);

  // First of the two samples, compared against the second at the slot's closing edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a <= 1'b0;
      s1_b <= 1'b0;
    end else if (state == SAMPLE) begin
      s1_a <= enc_a;
      s1_b <= enc_b;
    end
  end
`else
  assign sample_ok = sample_fire;
`endif

  // Settle countdown: SETTLE lasts CNT_LOAD+1 cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   settle_cnt <= '0;
    else if (load_cnt)                            settle_cnt <= CNT_LOAD;
    else if (state == SETTLE && settle_cnt != 0)  settle_cnt <= settle_cnt - 8'd1;
  end

  // Illegal jump: a primed channel whose A and B both changed since its last sample
  always_comb begin
    err_set = '0;
    if (sample_ok && primed[mux_sel] &&
        (enc_a != last_a[mux_sel]) && (enc_b != last_b[mux_sel]))
      err_set[mux_sel] = 1'b1;
  end

  // Sample capture, strobe, mux advance, channel history and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_sel <= '0;
      chan    <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      valid   <= 1'b0;
      err     <= '0;
      last_a  <= '0;
      last_b  <= '0;
      primed  <= '0;
    end else begin
      valid <= 1'b0;
      if (sample_fire) mux_sel <= mux_sel + 3'd1;
      if (sample_ok) begin
        chan            <= mux_sel;
        a_q             <= enc_a;
        b_q             <= enc_b;
        valid           <= 1'b1;
        last_a[mux_sel] <= enc_a;
        last_b[mux_sel] <= enc_b;
        primed[mux_sel] <= 1'b1;
      end
      // A new error in the same cycle as a clear keeps the bit set
      err <= (err & ~err_clr) | err_set;
    end
  end

endmodule

// File: doc/encoder_scanner.md
Name: encoder_scanner

Overview:
- Time-multiplexed front end for the 8-channel rotary encoder bank.
- Drives the select lines of an external 8:1 analogue mux that routes one encoder's A/B pair onto a single input pair.
- Waits for the mux to settle, samples A/B, and emits a channel-tagged one-cycle strobe that the encoder bank consumes.
- Flags illegal quadrature jumps (A and B both changing) per channel in sticky error bits readable by the CPU.

Parameters:
- SETTLE_CYCLES, 16, clk cycles the mux select is held before sampling; legal range 1..255.
- NUM_CHANNELS, 8, channels scanned; fixed at 8, select width 3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scan enable; level
- enc_a  in  1  muxed encoder A, already synchronised upstream
- enc_b  in  1  muxed encoder B, already synchronised upstream
- mux_sel  out  3  external mux select
- chan  out  3  channel of current sample
- a_q  out  1  sampled A
- b_q  out  1  sampled B
- valid  out  1  one-cycle strobe; chan/a_q/b_q valid while high
- err  out  8  sticky illegal-transition flags, bit per channel
- err_clr  in  8  write-1-to-clear mask for err, from CPU register write

Behaviour:
- Reset: mux_sel=0, chan=0, a_q=0, b_q=0, valid=0, err=0; all per-channel last-state and primed bits cleared; FSM=IDLE.
- FSM states: IDLE, SETTLE, SAMPLE.
- IDLE: enable=1 -> SETTLE, settle counter loaded with SETTLE_CYCLES-1; mux_sel unchanged.
- SETTLE: mux_sel held; counter decrements each cycle; at 0 -> SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE: lasts 1 cycle; enc_a/enc_b captured at its closing edge. At that same edge:
  - chan<=mux_sel; a_q/b_q<=inputs; valid<=1.
  - mux_sel<=mux_sel+1 (wraps 7->0); next state SETTLE, counter reloaded.
- valid is high for exactly the first cycle of the next slot, then 0.
- Slot length = SETTLE_CYCLES+1 cycles; full scan = 8*(SETTLE_CYCLES+1).
- Error check at sample edge, per channel:
  - Channel primed and both a and b differ from that channel's stored last state -> err[ch]<=1.
  - Stored last state is always updated; primed bit set on the channel's first sample, which never raises err.
- err_clr: bits clear err in the same edge. A new error on the same bit in the same cycle wins (bit stays 1).
- enable deasserted in SETTLE or SAMPLE: next edge -> IDLE, no valid for that slot, mux_sel keeps current channel. Re-enable restarts that channel with a full settle.
- Changes to enable within a cycle affect only the next edge; valid already asserted still completes its single cycle.
- Async reset mid-slot: immediate return to reset values; no partial strobe.

Optional Feature:
- Macro: ENCODER_SCANNER_FILTER_EN
- Defined:
  - SAMPLE becomes two cycles, SAMPLE1 then SAMPLE2, sampling A/B at each closing edge.
  - Both samples equal -> SAMPLE2 edge behaves as SAMPLE above.
  - Samples differ -> no valid, no error check, last state unchanged; mux_sel still advances.
  - Slot length = SETTLE_CYCLES+2.
- Not defined: single-sample SAMPLE as above; no extra logic.

Test Plan (all with SETTLE_CYCLES=4):
1. Reset, enable=1, enc_a=1, enc_b=0 constant -> mux_sel steps 0,1,..,7,0 every 5 cycles; valid pulses every 5 cycles with chan=0..7 in order, a_q=1, b_q=0; err stays 0.
2. Channel 3 samples 00 then, on next scan, 11 -> err=8'h08 after that strobe. err_clr=8'h08 in a cycle where no new error occurs -> err=0. Repeat with err_clr coinciding with a new ch3 error -> err stays 8'h08.
3. Channel 5 legal sequence 00,01,11,10,00 over 5 scans -> valid tagged chan=5 carries each value; err[5]=0.
4. Deassert enable 2 cycles into channel 2's SETTLE -> no valid for chan 2, mux_sel stays 2. Reassert -> chan 2 valid exactly 5 cycles later.
5. rst_n pulsed low mid-SETTLE on channel 6 -> all outputs 0 immediately. After release, the first ch6 sample raises no err even if both bits differ from the pre-reset value.
6. FILTER_EN built, enc_a toggled between SAMPLE1 and SAMPLE2 of channel 1 -> no valid for chan 1, mux_sel advances to 2 after 6 cycles. Stable inputs -> valid every 6 cycles.
